// File: rtl/fft_pkg.sv
// Shared constants, sample type and slot layout helper for the 8-point FFT datapath.
package fft_pkg;

  localparam int unsigned FFT_LEN      = 8;
  localparam int unsigned FFT_SAMPLE_W = 16;
  localparam int unsigned FFT_FRAME_W  = 256;

  // Packed so that {re, im} matches the per-slot bit layout of the frame word.
  typedef struct packed {
    logic signed [FFT_SAMPLE_W-1:0] re;
    logic signed [FFT_SAMPLE_W-1:0] im;
  } cplx_t;

  // Bit offset of slot k inside the frame word.
  function automatic int unsigned slot_offset(input int unsigned k);
    return 32 * k;
  endfunction

endpackage

// File: rtl/fft_frame_packer.sv
// Packs eight streamed complex samples into one FFT frame word, strobes enable,
// and regenerates a valid strobe aligned with the FFT's registered output.
module fft_frame_packer
  import fft_pkg::*;
#(
  parameter int unsigned LEN      = FFT_LEN,
  parameter int unsigned SAMPLE_W = FFT_SAMPLE_W,
  parameter int unsigned SCALE    = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic                   in_sof,
  input  logic [SAMPLE_W-1:0]    in_re,
  input  logic [SAMPLE_W-1:0]    in_im,
  output logic [FFT_FRAME_W-1:0] d,
  output logic                   enable,
  output logic                   dataout_valid,
  output logic [15:0]            frame_cnt,
  output logic [7:0]             drop_cnt,
  output logic                   err_short
);

  localparam int unsigned CntW = $clog2(LEN);
  localparam logic [CntW-1:0] LastSlot = CntW'(LEN - 1);

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [FFT_FRAME_W-1:0] collect_q, collect_d;
  logic [FFT_FRAME_W-1:0] d_q, d_d;
  logic                   enable_q, enable_d;
  logic [1:0]             dv_q, dv_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [7:0]             drop_cnt_q, drop_cnt_d;
  logic                   err_q, err_d;

  cplx_t           sample;
  logic [CntW-1:0] slot;
  logic            restart;

  always_comb begin
    sample.re = $signed(in_re) >>> SCALE;
    sample.im = $signed(in_im) >>> SCALE;
  end

  always_comb begin
    cnt_d       = cnt_q;
    collect_d   = collect_q;
    d_d         = d_q;
    enable_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    err_d       = 1'b0;
    // Two-stage delay covers FFT input capture plus its dataout register.
    dv_d        = {dv_q[0], enable_q};
    restart     = in_valid && in_sof && (cnt_q != '0);
    slot        = restart ? '0 : cnt_q;

    if (in_valid) begin
      collect_d[slot_offset(32'(slot)) +: $bits(cplx_t)] = sample;
      if (restart) begin
        cnt_d      = CntW'(1);
        err_d      = 1'b1;
        drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
      end else if (cnt_q == LastSlot) begin
        // Frame output takes the updated collect word so slot 7 lands on the same edge.
        d_d         = collect_d;
        enable_d    = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
        cnt_d       = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      collect_q   <= '0;
      d_q         <= '0;
      enable_q    <= 1'b0;
      dv_q        <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      collect_q   <= collect_d;
      d_q         <= d_d;
      enable_q    <= enable_d;
      dv_q        <= dv_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_q       <= err_d;
    end
  end

  assign d             = d_q;
  assign enable        = enable_q;
  assign dataout_valid = dv_q[1];
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;
  assign err_short     = err_q;

endmodule

// File: tb/tb_fft_frame_packer.sv
// Directed self-checking bench for fft_frame_packer (SCALE=0 and SCALE=2 instances).
module tb_fft_frame_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_sof;
  logic [15:0]  in_re;
  logic [15:0]  in_im;

  logic [255:0] d, d2;
  logic         enable, enable2;
  logic         dataout_valid, dataout_valid2;
  logic [15:0]  frame_cnt, frame_cnt2;
  logic [7:0]   drop_cnt, drop_cnt2;
  logic         err_short, err_short2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fft_frame_packer #(.LEN(8), .SAMPLE_W(16), .SCALE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_re(in_re), .in_im(in_im),
    .d(d), .enable(enable), .dataout_valid(dataout_valid), .frame_cnt(frame_cnt),
    .drop_cnt(drop_cnt), .err_short(err_short)
  );

  fft_frame_packer #(.LEN(8), .SAMPLE_W(16), .SCALE(2)) dut_scaled (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_re(in_re), .in_im(in_im),
    .d(d2), .enable(enable2), .dataout_valid(dataout_valid2), .frame_cnt(frame_cnt2),
    .drop_cnt(drop_cnt2), .err_short(err_short2)
  );

  // Slot k holds re = base+k+1, im = -(base+k+1).
  function automatic logic [255:0] ramp_frame(input int base);
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) f[32*k +: 32] = {16'(base + k + 1), 16'(-(base + k + 1))};
    return f;
  endfunction

  task automatic send(input logic sof, input logic [15:0] re, input logic [15:0] im);
    in_valid = 1'b1;
    in_sof   = sof;
    in_re    = re;
    in_im    = im;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_re    = '0;
    in_im    = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (d !== '0) begin failures++; $display("FAIL reset_d got=%h exp=0", d); end
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL reset_enable got=%b exp=0", enable); end
    checks++; if (dataout_valid !== 1'b0) begin
      failures++; $display("FAIL reset_dv got=%b exp=0", dataout_valid);
    end
    checks++; if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
    checks++; if (err_short !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_short); end
  endtask

  task automatic test_ramp();
    int sum;
    logic early;
    do_reset();
    early = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send(k == 0, 16'(k + 1), 16'(-(k + 1)));
      if (k < 7 && enable !== 1'b0) early = 1'b1;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL ramp_early_enable got=1 exp=0"); end
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL ramp_enable got=%b exp=1", enable); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL ramp_frame_cnt got=%0d exp=1", frame_cnt); end
    checks++; if (d[31:16] !== 16'd1 || d[15:0] !== 16'hFFFF) begin
      failures++; $display("FAIL ramp_slot0 got=%h exp=0001ffff", d[31:0]);
    end
    checks++; if (d[255:240] !== 16'd8 || d[239:224] !== 16'hFFF8) begin
      failures++; $display("FAIL ramp_slot7 got=%h exp=0008fff8", d[255:224]);
    end
    checks++; if (d !== ramp_frame(0)) begin failures++; $display("FAIL ramp_d got=%h exp=%h", d, ramp_frame(0)); end
    sum = 0;
    for (int k = 0; k < 8; k++) sum += int'($signed(d[32*k+16 +: 16]));
    checks++; if (sum !== 36) begin failures++; $display("FAIL ramp_bin0_re got=%0d exp=36", sum); end
    idle();
    checks++; if (enable !== 1'b0 || dataout_valid !== 1'b0) begin
      failures++; $display("FAIL ramp_n1 got en=%b dv=%b exp en=0 dv=0", enable, dataout_valid);
    end
    idle();
    checks++; if (dataout_valid !== 1'b1) begin failures++; $display("FAIL ramp_dv got=%b exp=1", dataout_valid); end
    idle();
    checks++; if (dataout_valid !== 1'b0) begin failures++; $display("FAIL ramp_dv_off got=%b exp=0", dataout_valid); end
    checks++; if (d !== ramp_frame(0)) begin failures++; $display("FAIL ramp_d_hold got=%h exp=%h", d, ramp_frame(0)); end
  endtask

  task automatic test_gapped();
    logic early;
    do_reset();
    early = 1'b0;
    for (int k = 0; k < 8; k++) begin
      send(1'b0, 16'(k + 1), 16'(-(k + 1)));
      if (k < 7) begin
        if (enable !== 1'b0) early = 1'b1;
        idle();
        if (enable !== 1'b0) early = 1'b1;
      end
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL gap_early_enable got=1 exp=0"); end
    checks++; if (enable !== 1'b1) begin failures++; $display("FAIL gap_enable got=%b exp=1", enable); end
    checks++; if (d !== ramp_frame(0)) begin failures++; $display("FAIL gap_d got=%h exp=%h", d, ramp_frame(0)); end
  endtask

  task automatic test_resync();
    int en_count;
    do_reset();
    en_count = 0;
    for (int k = 0; k < 5; k++) begin
      send(k == 0, 16'(100 + k), 16'(200 + k));
      if (enable === 1'b1) en_count++;
    end
    send(1'b1, 16'd1, 16'(-1));
    checks++; if (err_short !== 1'b1) begin failures++; $display("FAIL resync_err got=%b exp=1", err_short); end
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL resync_drop got=%0d exp=1", drop_cnt); end
    for (int k = 1; k < 8; k++) begin
      send(1'b0, 16'(k + 1), 16'(-(k + 1)));
      if (k == 1 && err_short !== 1'b0) begin
        checks++; failures++; $display("FAIL resync_err_width got=%b exp=0", err_short);
      end
      if (enable === 1'b1) en_count++;
    end
    checks++; if (en_count !== 1) begin failures++; $display("FAIL resync_enables got=%0d exp=1", en_count); end
    checks++; if (d !== ramp_frame(0)) begin failures++; $display("FAIL resync_d got=%h exp=%h", d, ramp_frame(0)); end
    checks++; if (frame_cnt !== 16'd1) begin failures++; $display("FAIL resync_frame_cnt got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_sof_at_slot7();
    do_reset();
    for (int k = 0; k < 7; k++) send(1'b0, 16'(50 + k), 16'(60 + k));
    send(1'b1, 16'd1, 16'(-1));
    checks++; if (enable !== 1'b0 || err_short !== 1'b1 || frame_cnt !== 16'd0) begin
      failures++;
      $display("FAIL sof7 got en=%b err=%b fc=%0d exp en=0 err=1 fc=0", enable, err_short, frame_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] en_seen, dv_seen;
    logic [255:0] exp_last;
    do_reset();
    en_seen = '0;
    dv_seen = '0;
    for (int t = 1; t <= 27; t++) begin
      if (t <= 24) send(1'b0, 16'(t), 16'(-t));
      else idle();
      en_seen[t] = enable;
      dv_seen[t] = dataout_valid;
    end
    checks++; if (en_seen !== 32'h0101_0100) begin
      failures++; $display("FAIL b2b_enable got=%h exp=01010100", en_seen);
    end
    checks++; if (dv_seen !== 32'h0404_0400) begin
      failures++; $display("FAIL b2b_dv got=%h exp=04040400", dv_seen);
    end
    checks++; if (frame_cnt !== 16'd3) begin failures++; $display("FAIL b2b_frame_cnt got=%0d exp=3", frame_cnt); end
    exp_last = ramp_frame(16);
    checks++; if (d !== exp_last) begin failures++; $display("FAIL b2b_d got=%h exp=%h", d, exp_last); end
  endtask

  task automatic test_scaling();
    do_reset();
    for (int k = 0; k < 8; k++) send(1'b0, 16'hFFF9, 16'h7FFF);
    checks++; if (d2[31:0] !== 32'hFFFE_1FFF) begin
      failures++; $display("FAIL scale_slot0 got=%h exp=fffe1fff", d2[31:0]);
    end
    checks++; if (d2[255:224] !== 32'hFFFE_1FFF) begin
      failures++; $display("FAIL scale_slot7 got=%h exp=fffe1fff", d2[255:224]);
    end
    checks++; if (d[31:0] !== 32'hFFF9_7FFF) begin
      failures++; $display("FAIL scale0_slot0 got=%h exp=fff97fff", d[31:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int en_count;
    do_reset();
    for (int k = 0; k < 6; k++) send(1'b0, 16'(70 + k), 16'(80 + k));
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++; if (drop_cnt !== 8'd0 || err_short !== 1'b0) begin
      failures++; $display("FAIL rstmid_drop got drop=%0d err=%b exp drop=0 err=0", drop_cnt, err_short);
    end
    en_count = 0;
    for (int k = 0; k < 8; k++) begin
      send(1'b0, 16'(k + 1), 16'(-(k + 1)));
      if (enable === 1'b1) en_count++;
    end
    checks++; if (en_count !== 1) begin failures++; $display("FAIL rstmid_enables got=%0d exp=1", en_count); end
    checks++; if (d !== ramp_frame(0)) begin failures++; $display("FAIL rstmid_d got=%h exp=%h", d, ramp_frame(0)); end
    checks++; if (drop_cnt !== 8'd0) begin failures++; $display("FAIL rstmid_drop_end got=%0d exp=0", drop_cnt); end
    // Reset right after completion must cancel the in-flight strobes.
    rst = 1'b1;
    idle();
    rst = 1'b0;
    checks++; if (enable !== 1'b0) begin failures++; $display("FAIL rstmid_cancel_en got=%b exp=0", enable); end
    idle();
    checks++; if (dataout_valid !== 1'b0) begin
      failures++; $display("FAIL rstmid_cancel_dv got=%b exp=0", dataout_valid);
    end
  endtask

  task automatic test_drop_saturate();
    do_reset();
    for (int i = 0; i < 257; i++) send(1'b1, 16'(i), 16'(i));
    checks++; if (drop_cnt !== 8'd255) begin failures++; $display("FAIL drop_sat got=%0d exp=255", drop_cnt); end
    send(1'b1, 16'd0, 16'd0);
    checks++; if (drop_cnt !== 8'd255 || err_short !== 1'b1) begin
      failures++; $display("FAIL drop_sat_hold got drop=%0d err=%b exp drop=255 err=1", drop_cnt, err_short);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_gapped();
    test_resync();
    test_sof_at_slot7();
    test_back_to_back();
    test_scaling();
    test_reset_mid_frame();
    test_drop_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
